// File: rtl/dfr_output_layer_if.sv
// Reservoir stream, weight memory and output memory bundle for the DFR readout.
// master: readout block; slave: surrounding core / memories.
interface dfr_output_layer_if #(
  parameter int DATA_WIDTH        = 32,
  parameter int WEIGHT_ADDR_WIDTH = 16,
  parameter int OUTPUT_ADDR_WIDTH = 16
);
  logic                         res_valid;
  logic [DATA_WIDTH-1:0]        res_data;
  logic                         res_ready;
  logic [WEIGHT_ADDR_WIDTH-1:0] weight_addr;
  logic                         weight_rd_en;
  logic [DATA_WIDTH-1:0]        weight_data;
  logic                         out_wr_en;
  logic [OUTPUT_ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0]        out_data;

  modport master (
    input  res_valid, res_data, weight_data,
    output res_ready, weight_addr, weight_rd_en,
    output out_wr_en, out_addr, out_data
  );

  modport slave (
    output res_valid, res_data, weight_data,
    input  res_ready, weight_addr, weight_rd_en,
    input  out_wr_en, out_addr, out_data
  );
endinterface

// File: rtl/dfr_output_layer.sv
// DFR readout: weighted sum of reservoir nodes, scaled and saturated per sample.
// Optional output bias word (weight address VIRTUAL_NODES): DFR_OUTPUT_BIAS_EN.
module dfr_output_layer #(
  parameter int VIRTUAL_NODES     = 100,
  parameter int DATA_WIDTH        = 32,
  parameter int WEIGHT_ADDR_WIDTH = 16,
  parameter int OUTPUT_ADDR_WIDTH = 16,
  parameter int ACC_WIDTH         = 72,
  parameter int OUT_SHIFT         = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] num_samples,
  output logic        busy,
  output logic        done,
  dfr_output_layer_if.master bus
);

  localparam int NW = $clog2(VIRTUAL_NODES + 1);
  localparam int PW = 2 * DATA_WIDTH;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] BIAS  = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic signed [ACC_WIDTH-1:0] MAXV =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MINV =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic [2:0]                  state;
  logic [NW-1:0]               node_idx;
  logic [NW-1:0]               node_nxt;
  logic [31:0]                 sample_cnt;
  logic [31:0]                 num_q;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] shifted;
  logic signed [ACC_WIDTH-1:0] prod_x;
  logic signed [ACC_WIDTH-1:0] bias_x;
  logic signed [PW-1:0]        prod;
  logic [DATA_WIDTH-1:0]       sat;
  logic [DATA_WIDTH-1:0]       out_q;
  logic                        hs;
  logic                        last_node;
  logic                        last_sample;

  assign hs          = bus.res_valid && bus.res_ready;
  assign node_nxt    = node_idx + NW'(1);
  assign last_node   = node_idx == NW'(VIRTUAL_NODES - 1);
  assign last_sample = sample_cnt == num_q - 32'd1;

  // Low PW bits of the product of sign-extended operands is the exact product.
  assign prod = $signed({{DATA_WIDTH{bus.res_data[DATA_WIDTH-1]}}, bus.res_data})
              * $signed({{DATA_WIDTH{bus.weight_data[DATA_WIDTH-1]}}, bus.weight_data});
  assign prod_x = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
  assign bias_x = {{(ACC_WIDTH-DATA_WIDTH){bus.weight_data[DATA_WIDTH-1]}},
                   bus.weight_data} <<< OUT_SHIFT;

  assign shifted = acc >>> OUT_SHIFT;

  always_comb begin
    sat = shifted[DATA_WIDTH-1:0];
    if (shifted > MAXV)
      sat = MAXV[DATA_WIDTH-1:0];
    else if (shifted < MINV)
      sat = MINV[DATA_WIDTH-1:0];
  end

  always_comb begin
    bus.res_ready    = state == RUN;
    bus.weight_rd_en = 1'b0;
    bus.weight_addr  = '0;
    case (state)
      FETCH: bus.weight_rd_en = 1'b1;
      RUN: begin
        bus.weight_rd_en = 1'b1;
        bus.weight_addr  = WEIGHT_ADDR_WIDTH'(node_idx);
`ifdef DFR_OUTPUT_BIAS_EN
        if (hs)
          bus.weight_addr = WEIGHT_ADDR_WIDTH'(node_nxt);
`else
        if (hs && !last_node)
          bus.weight_addr = WEIGHT_ADDR_WIDTH'(node_nxt);
        if (hs && last_node)
          bus.weight_rd_en = 1'b0;
`endif
      end
      WRITE: bus.weight_rd_en = !last_sample;
      default: ;
    endcase
  end

  assign bus.out_wr_en = state == WRITE;
  assign bus.out_addr  = sample_cnt[OUTPUT_ADDR_WIDTH-1:0];
  assign bus.out_data  = (state == WRITE) ? sat : out_q;

  assign busy = (state == FETCH) || (state == RUN)
             || (state == BIAS) || (state == WRITE);
  assign done = state == DONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      node_idx   <= '0;
      sample_cnt <= '0;
      num_q      <= '0;
      acc        <= '0;
      out_q      <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          num_q      <= num_samples;
          sample_cnt <= '0;
          state      <= (num_samples == 32'd0) ? DONE : FETCH;
        end
        FETCH: begin
          node_idx <= '0;
          acc      <= '0;
          state    <= RUN;
        end
        RUN: if (hs) begin
          acc      <= acc + prod_x;
          node_idx <= node_nxt;
`ifdef DFR_OUTPUT_BIAS_EN
          if (last_node) state <= BIAS;
`else
          if (last_node) state <= WRITE;
`endif
        end
`ifdef DFR_OUTPUT_BIAS_EN
        BIAS: begin
          acc   <= acc + bias_x;
          state <= WRITE;
        end
`endif
        WRITE: begin
          out_q <= sat;
          if (last_sample) begin
            state <= DONE;
          end else begin
            sample_cnt <= sample_cnt + 32'd1;
            acc        <= '0;
            node_idx   <= '0;
            state      <= RUN;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dfr_output_layer.sv
// Scoreboard bench for dfr_output_layer (VIRTUAL_NODES=4, OUT_SHIFT=0).
// Expectations include the +5 bias word when DFR_OUTPUT_BIAS_EN is defined.
module tb_dfr_output_layer;
  localparam int VN = 4;
  localparam int DW = 32;
  localparam int WA = 16;
  localparam int OA = 16;
`ifdef DFR_OUTPUT_BIAS_EN
  localparam int BIASV = 5;
  localparam int LAT   = 2;
  localparam int MAXA  = VN;
`else
  localparam int BIASV = 0;
  localparam int LAT   = 1;
  localparam int MAXA  = VN - 1;
`endif

  typedef struct {
    logic [OA-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] num_samples = '0;
  logic        busy;
  logic        done;

  dfr_output_layer_if #(
    .DATA_WIDTH(DW), .WEIGHT_ADDR_WIDTH(WA), .OUTPUT_ADDR_WIDTH(OA)
  ) bus ();

  dfr_output_layer #(
    .VIRTUAL_NODES(VN), .DATA_WIDTH(DW), .WEIGHT_ADDR_WIDTH(WA),
    .OUTPUT_ADDR_WIDTH(OA), .ACC_WIDTH(72), .OUT_SHIFT(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] wmem [0:VN];

  always @(posedge clk)
    if (bus.weight_rd_en)
      bus.weight_data <= (int'(bus.weight_addr) <= VN)
                       ? wmem[int'(bus.weight_addr)] : '0;

  exp_t exp_q[$];
  int   hs_q[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, hs_n = 0, wr_n = 0, done_n = 0, bad_rd = 0;
  int   last_hs = 0, last_wr = 0, run_wr = 0, start_cyc = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every output write.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst) begin
      if (bus.res_valid && bus.res_ready) begin
        hs_n++;
        last_hs = cyc;
        hs_q.push_back(cyc);
      end
      if (bus.weight_rd_en && int'(bus.weight_addr) > MAXA)
        bad_rd++;
      if (bus.out_wr_en) begin
        wr_n++;
        run_wr++;
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(bus.out_addr), 64'(e.a));
          check("wr_data", 64'(bus.out_data), 64'(e.d));
        end
        check("wr_latency", 64'(cyc - last_hs), 64'(LAT));
        check("wr_busy", 64'(busy), 64'd1);
        last_wr = cyc;
      end
      if (done) begin
        done_n++;
        check("done_busy", 64'(busy), 64'd0);
        if (run_wr > 0)
          check("done_after_wr", 64'(cyc - last_wr), 64'd1);
        else
          check("done_zero_lat", 64'(cyc - start_cyc), 64'd2);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go(input int n);
    num_samples = n;
    start = 1'b1;
    start_cyc = cyc;
    run_wr = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d);
    bit ok = 1'b0;
    int n = 0;
    bus.res_valid = 1'b1;
    bus.res_data  = d;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = bus.res_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.res_valid = 1'b0;
    if (!ok) check("res_ready_timeout", 64'(ok), 64'd1);
  endtask

  // mode 1: valid drops for one cycle after each value; gap: extra idle cycles after node 1
  task automatic sample(input logic [DW-1:0] v0, v1, v2, v3,
                        input int mode, input int gap);
    logic [DW-1:0] v [4];
    v = '{v0, v1, v2, v3};
    for (int i = 0; i < 4; i++) begin
      send(v[i]);
      if (mode == 1) tick();
      if (i == 1 && gap > 0) tick(gap);
    end
  endtask

  task automatic wait_done();
    int d0 = done_n;
    int n = 0;
    while (done_n == d0 && n < 300) begin
      tick();
      n++;
    end
    check("done_seen", 64'(done_n - d0), 64'd1);
    tick();
  endtask

  task automatic push(input int a, input logic [DW-1:0] d);
    exp_t e;
    e.a = OA'(a);
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_ready"}, 64'(bus.res_ready), 64'd0);
    check({tag, "_rd_en"}, 64'(bus.weight_rd_en), 64'd0);
    check({tag, "_wr_en"}, 64'(bus.out_wr_en), 64'd0);
    check({tag, "_waddr"}, 64'(bus.weight_addr), 64'd0);
    check({tag, "_oaddr"}, 64'(bus.out_addr), 64'd0);
    check({tag, "_odata"}, 64'(bus.out_data), 64'd0);
  endtask

  task automatic run_three(input int mode, input int gap);
    hs_q.delete();
    push(0, DW'(10 + BIASV));
    push(1, DW'(20 + BIASV));
    push(2, DW'(-1 + BIASV));
    go(3);
    sample(1, 1, 1, 1, mode, 0);
    sample(2, 2, 2, 2, mode, gap);
    sample(32'hFFFF_FFFF, 0, 0, 0, mode, 0);
    wait_done();
    check("hs_count", 64'(hs_q.size()), 64'd12);
  endtask

  initial begin
    int d0, w0;
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    for (int i = 0; i < VN; i++) wmem[i] = DW'(i + 1);
    wmem[VN] = DW'(5);
    tick(3);
    check_reset("rst");
    rst = 1'b0;
    tick();

    push(0, DW'(10 + BIASV));
    go(1);
    sample(1, 1, 1, 1, 0, 0);
    wait_done();

    run_three(0, 0);
    for (int s = 0; s < 3; s++)
      check("no_stall", 64'(hs_q[4*s+3] - hs_q[4*s]), 64'd3);

    run_three(1, 5);

    for (int i = 0; i < VN; i++) wmem[i] = 32'h7FFF_FFFF;
    push(0, 32'h7FFF_FFFF);
    go(1);
    sample(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0);
    wait_done();
    push(0, 32'h8000_0000);
    go(1);
    sample(32'h8000_0001, 32'h8000_0001, 32'h8000_0001, 32'h8000_0001, 0, 0);
    wait_done();
    for (int i = 0; i < VN; i++) wmem[i] = DW'(i + 1);

    w0 = wr_n;
    go(0);
    wait_done();
    check("zero_no_write", 64'(wr_n - w0), 64'd0);

    d0 = done_n;
    w0 = wr_n;
    push(0, DW'(10 + BIASV));
    go(1);
    send(1);
    send(1);
    num_samples = 5;
    start = 1'b1;
    tick();
    start = 1'b0;
    send(1);
    send(1);
    wait_done();
    tick(10);
    check("restart_done", 64'(done_n - d0), 64'd1);
    check("restart_wr", 64'(wr_n - w0), 64'd1);

    go(1);
    send(7);
    send(7);
    rst = 1'b1;
    tick();
    check_reset("midrst");
    rst = 1'b0;
    tick();
    push(0, DW'(10 + BIASV));
    go(1);
    sample(1, 1, 1, 1, 0, 0);
    wait_done();

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    check("weight_addr_range", 64'(bad_rd), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dfr_output_layer.md
Name: dfr_output_layer

Overview:
Readout stage directly downstream of the DFR reservoir inside dfr_core_top. It consumes the stream of VIRTUAL_NODES reservoir node values for each test sample and multiplies each value by the matching trained weight from the weight memory. It accumulates the products, then scales and saturates the sum. It writes one result word per sample into the DFR output memory, which software reads back over AXI.

Parameters:
VIRTUAL_NODES, 100, reservoir node values (and weights) per sample
DATA_WIDTH, 32, width of reservoir values, weights and outputs (signed two's complement)
WEIGHT_ADDR_WIDTH, 16, weight memory address width
OUTPUT_ADDR_WIDTH, 16, output memory address width
ACC_WIDTH, 72, signed accumulator width
OUT_SHIFT, 16, arithmetic right shift applied to the accumulator before saturation

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that launches a readout run
num_samples  in  32  samples to process in this run
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at the end of a run
res_valid  in  1  reservoir value valid
res_data  in  DATA_WIDTH  reservoir node value, node order 0..VIRTUAL_NODES-1
res_ready  out  1  block accepts res_data
weight_addr  out  WEIGHT_ADDR_WIDTH  weight memory read address
weight_rd_en  out  1  weight memory read enable
weight_data  in  DATA_WIDTH  weight memory data, 1-cycle read latency
out_wr_en  out  1  output memory write strobe
out_addr  out  OUTPUT_ADDR_WIDTH  output memory address (sample index)
out_data  out  DATA_WIDTH  scaled and saturated result

Behaviour:
- Reset (synchronous, active-high): state IDLE. busy, done, res_ready, weight_rd_en and out_wr_en are 0. weight_addr, out_addr, out_data, node_idx, sample_idx and the accumulator are 0. Reset mid-run aborts the run with no further writes and no done pulse.
- A handshake occurs when res_valid && res_ready.
- States:
  - IDLE: start=1 latches num_samples. If num_samples==0 go to DONE, otherwise go to FETCH. start is ignored in any state other than IDLE.
  - FETCH (1 cycle): weight_rd_en=1, weight_addr=0. Clear node_idx and the accumulator. Go to RUN.
  - RUN: res_ready=1. On a handshake:
    - acc += sext(res_data) * sext(weight_data), full-precision signed product.
    - The same cycle issues weight_addr=node_idx+1 with weight_rd_en=1, so the next weight arrives the next cycle. This sustains one handshake per cycle.
    - With no handshake, weight_addr holds node_idx and weight_data stays valid.
    - A handshake with node_idx==VIRTUAL_NODES-1 goes to WRITE (or BIAS when the optional feature is compiled in). res_ready is 0 outside RUN.
  - WRITE (1 cycle):
    - out_wr_en=1, out_addr=sample_idx.
    - out_data = saturate(acc >>> OUT_SHIFT) to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
    - If sample_idx==num_samples-1 go to DONE. Otherwise sample_idx++, clear acc and node_idx, issue weight_addr=0, and go to RUN.
  - DONE (1 cycle): done=1, busy=0 in this cycle. Go to IDLE.
- Latency: out_wr_en asserts exactly 1 cycle after the last node handshake of a sample (2 cycles with the bias feature).
- sample_idx wraps modulo 2^OUTPUT_ADDR_WIDTH. Software bounds num_samples; the block does not check it.
- out_data holds its last value outside WRITE.

Optional Feature:
DFR_OUTPUT_BIAS_EN:
- Defined: the last node handshake also issues weight_addr=VIRTUAL_NODES and enters BIAS for 1 cycle. In BIAS, acc += sext(weight_data) << OUT_SHIFT (bias is an unscaled output-domain offset), then go to WRITE. Weight memory holds VIRTUAL_NODES+1 words.
- Undefined: no BIAS state; address VIRTUAL_NODES is never read.

Test Plan:
- VIRTUAL_NODES=4, OUT_SHIFT=0, weights {1,2,3,4}, res {1,1,1,1}, num_samples=1 -> single write addr 0, data 10; done 1 cycle later; busy falls with done.
- Same weights, num_samples=3, res_valid held high, res {1,1,1,1},{2,2,2,2},{-1,0,0,0} -> writes 10,20,-1 at addrs 0,1,2. The 4 node handshakes of each sample occur in 4 consecutive cycles (no stalls within a sample).
- res_valid toggling 1/0 every cycle plus a 5-cycle gap mid-sample -> identical outputs to the previous scenario; no extra or missed handshakes.
- Weights all 0x7FFFFFFF, res all 0x7FFFFFFF, OUT_SHIFT=0 -> out_data 0x7FFFFFFF. Res all 0x80000001 with the same weights -> out_data 0x80000000.
- num_samples=0 -> done pulse 2 cycles after start, out_wr_en never asserted. A start pulse during a run -> ignored, no restart.
- rst asserted mid-sample, then start with num_samples=1 and the first scenario's data -> result 10, with no residue from the aborted run. With DFR_OUTPUT_BIAS_EN and bias weight 5 -> result 15.
